// File: rtl/ps2_pkg.sv
// ---------------------------------------------------------------------------
// ps2_pkg
// Shared definitions for the PS/2 key tracker slice:
//   - rx_state_t : receiver FSM states (IDLE, DATA, PARITY, STOP)
//   - PS2_BREAK  : scan-code prefix announcing a key release (0xF0)
//   - PS2_EXT    : scan-code prefix announcing an extended key (0xE0)
//   - ps2_evt_t  : one key event, {make, code[8:0]} with code = {ext, scan}
// ---------------------------------------------------------------------------
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } rx_state_t;

    localparam logic [7:0] PS2_BREAK = 8'hF0;
    localparam logic [7:0] PS2_EXT   = 8'hE0;

    typedef struct packed {
        logic       make;
        logic [8:0] code;
    } ps2_evt_t;

    localparam int EVT_W = $bits(ps2_evt_t);

endpackage

// File: rtl/ps2_evt_fifo.sv
// ---------------------------------------------------------------------------
// ps2_evt_fifo
// First-word-fall-through FIFO holding key events between the decoder and
// the consumer. A push into a full FIFO is dropped and latches a sticky
// overflow flag, unless a pop happens in the same cycle, in which case both
// are accepted.
//
// Parameters:
//   FIFO_DEPTH  number of entries, power of two, >= 2
// Ports:
//   i_clk       clock, rising edge
//   i_rst_n     asynchronous active-low reset
//   i_push      write request, i_data is stored if there is room
//   i_data      event to store
//   i_pop       read request, honoured only while o_valid is high
//   o_data      head entry (zero while empty)
//   o_valid     FIFO non-empty
//   o_overflow  sticky, set when a push is dropped; cleared by reset only
// ---------------------------------------------------------------------------
module ps2_evt_fifo
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH = 8
)(
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [EVT_W-1:0] i_data,
    input  logic             i_pop,
    output logic [EVT_W-1:0] o_data,
    output logic             o_valid,
    output logic             o_overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [EVT_W-1:0] r_mem [FIFO_DEPTH];
    logic [AW:0]      r_wrPtr;
    logic [AW:0]      r_rdPtr;
    logic             r_overflow;

    logic w_empty;
    logic w_full;
    logic w_doPop;
    logic w_doPush;

    // Pointers carry one extra wrap bit so full and empty can be told apart.
    assign w_empty  = (r_wrPtr == r_rdPtr);
    assign w_full   = (r_wrPtr[AW] != r_rdPtr[AW]) &&
                      (r_wrPtr[AW-1:0] == r_rdPtr[AW-1:0]);
    assign w_doPop  = i_pop && !w_empty;
    // A simultaneous pop frees the slot the push needs, even when full.
    assign w_doPush = i_push && (!w_full || w_doPop);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wrPtr    <= '0;
            r_rdPtr    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_doPush) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_doPop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            if (i_push && !w_doPush) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Storage needs no reset: nothing is visible until it has been written.
    always_ff @(posedge i_clk) begin
        if (w_doPush) begin
            r_mem[r_wrPtr[AW-1:0]] <= i_data;
        end
    end

    // Head is forced to zero while empty so the outputs are clean in reset.
    assign o_data     = w_empty ? '0 : r_mem[r_rdPtr[AW-1:0]];
    assign o_valid    = !w_empty;
    assign o_overflow = r_overflow;

endmodule

// File: rtl/ps2_key_tracker.sv
// ---------------------------------------------------------------------------
// ps2_key_tracker
// Receives PS/2 keyboard frames, decodes make/break/extended scan codes,
// keeps a small table of currently held keys and queues key events in a
// FIFO (ps2_evt_fifo).
//
// Pipeline: stop-bit falling edge detected in cycle N, received byte is
// presented to the decoder in N+1, event and table update visible in N+2.
//
// Optional feature: define PS2_EXT_CODE_EN to honour the 0xE0 extended
// prefix (ext bit of the code can be 1). Without it, 0xE0 bytes are ignored
// and the ext bit is always 0.
//
// Parameters:
//   NUM_KEYS        held-key slots (1..8)
//   FIFO_DEPTH      event FIFO depth (power of two, >= 2)
//   TIMEOUT_CYCLES  idle clocks after which a partial frame is abandoned
// Ports:
//   iCLK_50     clock, rising edge
//   iRST_n      asynchronous active-low reset
//   ps2_clk_in  raw PS/2 clock line (input only)
//   ps2_dat_in  raw PS/2 data line (input only)
//   evt_valid   event FIFO non-empty
//   evt_ready   consumer pops head when evt_valid && evt_ready
//   evt_make    head event: 1 = make, 0 = break
//   evt_code    head event code {ext, scan}
//   scandata    last correctly received byte, prefixes included
//   key_on      per-slot occupied flags
//   key_code    per-slot codes, slot i at [9i+8:9i]
//   frame_err   one-cycle pulse on parity, stop-bit or timeout error
//   overflow    sticky, an event was dropped on a full FIFO
// ---------------------------------------------------------------------------
module ps2_key_tracker
    import ps2_pkg::*;
#(
    parameter int NUM_KEYS       = 2,
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 50000
)(
    input  logic                  iCLK_50,
    input  logic                  iRST_n,
    input  logic                  ps2_clk_in,
    input  logic                  ps2_dat_in,
    output logic                  evt_valid,
    input  logic                  evt_ready,
    output logic                  evt_make,
    output logic [8:0]            evt_code,
    output logic [7:0]            scandata,
    output logic [NUM_KEYS-1:0]   key_on,
    output logic [9*NUM_KEYS-1:0] key_code,
    output logic                  frame_err,
    output logic                  overflow
);

    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    // Synchroniser and edge detector
    logic [1:0] r_clkSync;
    logic [1:0] r_datSync;
    logic       r_clkPrev;
    logic       w_fall;
    logic       w_bit;

    // Receiver
    rx_state_t  r_state;
    rx_state_t  w_stateNext;
    logic [7:0] r_shift;
    logic [7:0] w_shiftNext;
    logic [2:0] r_bitCnt;
    logic [2:0] w_bitCntNext;
    logic       r_parityOk;
    logic       w_parityNext;
    logic [TO_W-1:0] r_idleCnt;
    logic       w_timeout;
    logic       w_emit;
    logic       w_err;
    logic [7:0] r_rxByte;
    logic       r_rxValid;
    logic       r_frameErr;

    // Decoder and slot table
    logic                  r_pendBreak;
    logic                  r_pendExt;
    logic                  w_isBreakByte;
    logic                  w_isExtByte;
    logic                  w_isKey;
    logic                  w_make;
    logic [8:0]            w_code;
    logic                  w_hit;
    logic                  w_fill;
    logic                  w_placed;
    logic                  w_push;
    logic [NUM_KEYS-1:0]   r_keyOn;
    logic [NUM_KEYS-1:0]   w_keyOnNext;
    logic [9*NUM_KEYS-1:0] r_keyCode;
    logic [9*NUM_KEYS-1:0] w_keyCodeNext;
    ps2_evt_t              w_evtIn;
    ps2_evt_t              w_evtOut;
    logic                  w_fifoOverflow;
    logic                  w_fifoValid;

    // Two-flop synchronisers idle high like the PS/2 bus, plus one more flop
    // on the clock so a 1 -> 0 transition of the synced clock is seen.
    always_ff @(posedge iCLK_50 or negedge iRST_n) begin
        if (!iRST_n) begin
            r_clkSync <= 2'b11;
            r_datSync <= 2'b11;
            r_clkPrev <= 1'b1;
        end else begin
            r_clkSync <= {r_clkSync[0], ps2_clk_in};
            r_datSync <= {r_datSync[0], ps2_dat_in};
            r_clkPrev <= r_clkSync[1];
        end
    end

    assign w_fall = r_clkPrev && !r_clkSync[1];
    assign w_bit  = r_datSync[1];

    // Idle counter: restarts at 1 on every falling edge, so in the cycle it
    // reads TIMEOUT_CYCLES-1 the registered error lands exactly
    // TIMEOUT_CYCLES cycles after the cycle the last edge was seen.
    assign w_timeout = (r_idleCnt == TO_W'(TIMEOUT_CYCLES - 1));

    // Receiver state register and per-frame data path registers.
    always_ff @(posedge iCLK_50 or negedge iRST_n) begin
        if (!iRST_n) begin
            r_state    <= IDLE;
            r_shift    <= '0;
            r_bitCnt   <= '0;
            r_parityOk <= 1'b0;
            r_idleCnt  <= '0;
            r_rxByte   <= '0;
            r_rxValid  <= 1'b0;
            r_frameErr <= 1'b0;
        end else begin
            r_state    <= w_stateNext;
            r_shift    <= w_shiftNext;
            r_bitCnt   <= w_bitCntNext;
            r_parityOk <= w_parityNext;
            r_rxValid  <= w_emit;
            r_frameErr <= w_err;
            if (w_emit) begin
                r_rxByte <= r_shift;
            end
            if (w_fall) begin
                r_idleCnt <= TO_W'(1);
            end else if (r_state == IDLE) begin
                r_idleCnt <= '0;
            end else begin
                r_idleCnt <= r_idleCnt + TO_W'(1);
            end
        end
    end

    // Receiver next-state logic. Every bit is taken on a synced falling
    // edge; a high data line at a falling edge in IDLE is simply ignored.
    always_comb begin
        w_stateNext  = r_state;
        w_shiftNext  = r_shift;
        w_bitCntNext = r_bitCnt;
        w_parityNext = r_parityOk;
        w_emit       = 1'b0;
        w_err        = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_fall && !w_bit) begin
                    w_stateNext  = DATA;
                    w_bitCntNext = '0;
                end
            end
            DATA: begin
                if (w_fall) begin
                    w_shiftNext  = {w_bit, r_shift[7:1]};
                    w_bitCntNext = r_bitCnt + 3'd1;
                    if (r_bitCnt == 3'd7) begin
                        w_stateNext = PARITY;
                    end
                end
            end
            PARITY: begin
                if (w_fall) begin
                    w_parityNext = ^{r_shift, w_bit};
                    w_stateNext  = STOP;
                end
            end
            STOP: begin
                if (w_fall) begin
                    w_stateNext = IDLE;
                    if (w_bit && r_parityOk) begin
                        w_emit = 1'b1;
                    end else begin
                        w_err = 1'b1;
                    end
                end
            end
            default: begin
                w_stateNext = IDLE;
            end
        endcase
        if ((r_state != IDLE) && !w_fall && w_timeout) begin
            w_stateNext = IDLE;
            w_err       = 1'b1;
        end
    end

    // Byte classification: prefixes only arm flags, anything else is a key.
    always_comb begin
        w_isBreakByte = r_rxValid && (r_rxByte == PS2_BREAK);
        w_isExtByte   = r_rxValid && (r_rxByte == PS2_EXT);
        w_isKey       = r_rxValid && !w_isBreakByte && !w_isExtByte;
        w_make        = !r_pendBreak;
        w_code        = {r_pendExt, r_rxByte};
    end

    // Pending prefix flags; both drop together when a key byte consumes them.
    always_ff @(posedge iCLK_50 or negedge iRST_n) begin
        if (!iRST_n) begin
            r_pendBreak <= 1'b0;
            r_pendExt   <= 1'b0;
        end else begin
            if (w_isBreakByte) begin
                r_pendBreak <= 1'b1;
            end else if (w_isKey) begin
                r_pendBreak <= 1'b0;
            end
`ifdef PS2_EXT_CODE_EN
            if (w_isExtByte) begin
                r_pendExt <= 1'b1;
            end else if (w_isKey) begin
                r_pendExt <= 1'b0;
            end
`else
            r_pendExt <= 1'b0;
`endif
        end
    end

    // Slot table update and event generation. A make of a held code is a
    // typematic repeat and is swallowed; a new make takes the lowest free
    // slot (or none if full) but always emits; a break clears all matches.
    always_comb begin
        w_hit         = 1'b0;
        w_placed      = 1'b0;
        w_push        = 1'b0;
        w_keyOnNext   = r_keyOn;
        w_keyCodeNext = r_keyCode;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (r_keyOn[i] && (r_keyCode[9*i +: 9] == w_code)) begin
                w_hit = 1'b1;
            end
        end
        w_fill = w_isKey && w_make && !w_hit;
        if (w_fill) begin
            w_push = 1'b1;
            for (int i = 0; i < NUM_KEYS; i++) begin
                if (!w_placed && !r_keyOn[i]) begin
                    w_keyOnNext[i]          = 1'b1;
                    w_keyCodeNext[9*i +: 9] = w_code;
                    w_placed                = 1'b1;
                end
            end
        end else if (w_isKey && !w_make) begin
            w_push = 1'b1;
            for (int i = 0; i < NUM_KEYS; i++) begin
                if (r_keyOn[i] && (r_keyCode[9*i +: 9] == w_code)) begin
                    w_keyOnNext[i]          = 1'b0;
                    w_keyCodeNext[9*i +: 9] = '0;
                end
            end
        end
    end

    // Slot table register.
    always_ff @(posedge iCLK_50 or negedge iRST_n) begin
        if (!iRST_n) begin
            r_keyOn   <= '0;
            r_keyCode <= '0;
        end else begin
            r_keyOn   <= w_keyOnNext;
            r_keyCode <= w_keyCodeNext;
        end
    end

    always_comb begin
        w_evtIn.make = w_make;
        w_evtIn.code = w_code;
    end

    ps2_evt_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk      (iCLK_50),
        .i_rst_n    (iRST_n),
        .i_push     (w_push),
        .i_data     (w_evtIn),
        .i_pop      (evt_ready),
        .o_data     (w_evtOut),
        .o_valid    (w_fifoValid),
        .o_overflow (w_fifoOverflow)
    );

    assign evt_valid = w_fifoValid;
    assign evt_make  = w_evtOut.make;
    assign evt_code  = w_evtOut.code;
    assign scandata  = r_rxByte;
    assign key_on    = r_keyOn;
    assign key_code  = r_keyCode;
    assign frame_err = r_frameErr;
    assign overflow  = w_fifoOverflow;

endmodule
